game_sequencer: RTL

Frame-synchronous game-flow controller for the breakout datapath. It sequences the ball, paddle and score blocks through idle, serve, play, pause, life-lost, level-clear and game-over phases. Inputs are debounced button pulses and collision events from the ball logic. Outputs are run enables, ball re-park requests, score increments and the lives and level counts.

---
 rtl/breakout_pkg.sv | 28 ++
 rtl/frame_timer.sv | 29 ++
 rtl/game_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/breakout_pkg.sv
// Shared types and defaults for the breakout game-flow controller.
// State encodings, default game parameters and the frame-timer width helper.
package breakout_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        LOST   = 3'd4,
        CLEAR  = 3'd5,
        OVER   = 3'd6
    } seq_state_e;

    localparam int unsigned LIVES_DEFAULT        = 3;
    localparam int unsigned SERVE_FRAMES_DEFAULT = 60;
    localparam int unsigned LOST_FRAMES_DEFAULT  = 90;
    localparam int unsigned MAX_LEVEL_DEFAULT    = 7;
    localparam int unsigned CNT_W                = 3;

    // Bits needed to hold the longer of the two frame waits.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame-tick down-counter shared by the serve and hold waits.
// done_c fires in the cycle that makes the wait complete, so the FSM exits right after it.
module frame_timer #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done_c
);

    logic [W-1:0] count;

    // A load on the same edge as a tick wins, so a tick coincident with entry is not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (frame_tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done_c = (count == '0) || ((count == W'(1)) && frame_tick);

endmodule

// File: rtl/game_sequencer.sv
// Frame-synchronous breakout game-flow controller (idle/serve/play/pause/lost/clear/over).
// Optional feature: define GAME_SEQ_PAUSE_EN to enable the pause button and PAUSED state.
module game_sequencer
    import breakout_pkg::*;
#(
    parameter int unsigned LIVES        = LIVES_DEFAULT,
    parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEFAULT,
    parameter int unsigned LOST_FRAMES  = LOST_FRAMES_DEFAULT,
    parameter int unsigned MAX_LEVEL    = MAX_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             launch,
    input  logic             pause,
    input  logic             ball_lost,
    input  logic             brick_hit,
    input  logic             bricks_clear,
    output logic [2:0]       state,
    output logic             ball_run,
    output logic             paddle_en,
    output logic             ball_reset,
    output logic             score_inc,
    output logic [CNT_W-1:0] lives,
    output logic [CNT_W-1:0] level,
    output logic             game_over
);

    localparam int unsigned TMR_W = timer_width(SERVE_FRAMES, LOST_FRAMES);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] lives_d;
    logic [CNT_W-1:0] level_d;
    logic             ball_reset_d;
    logic             ball_run_d;
    logic             paddle_en_d;
    logic             score_inc_d;
    logic             game_over_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_done_c;

`ifndef GAME_SEQ_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause;
`endif

    frame_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done_c     (tmr_done_c)
    );

    // State and all outputs registered together so enables track the state exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ball_run   <= 1'b0;
            paddle_en  <= 1'b0;
            ball_reset <= 1'b0;
            score_inc  <= 1'b0;
            lives      <= CNT_W'(LIVES);
            level      <= '0;
            game_over  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ball_run   <= ball_run_d;
            paddle_en  <= paddle_en_d;
            ball_reset <= ball_reset_d;
            score_inc  <= score_inc_d;
            lives      <= lives_d;
            level      <= level_d;
            game_over  <= game_over_d;
        end
    end

    assign state = 3'(state_q);

    // Next-state, counter updates and timer loads.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives;
        level_d      = level;
        ball_reset_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_value    = '0;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d      = SERVE;
                    ball_reset_d = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_value    = TMR_W'(SERVE_FRAMES);
                end
            end
            SERVE: begin
                if (tmr_done_c) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (bricks_clear) begin
                    state_d   = CLEAR;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(LOST_FRAMES);
                end else if (ball_lost) begin
                    state_d   = LOST;
                    lives_d   = (lives == '0) ? '0 : lives - CNT_W'(1);
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(LOST_FRAMES);
                end
`ifdef GAME_SEQ_PAUSE_EN
                else if (pause) begin
                    state_d = PAUSED;
                end
`endif
            end
`ifdef GAME_SEQ_PAUSE_EN
            PAUSED: begin
                if (pause) begin
                    state_d = PLAY;
                end
            end
`endif
            LOST: begin
                if (tmr_done_c) begin
                    if (lives == '0) begin
                        state_d = OVER;
                    end else begin
                        state_d      = SERVE;
                        ball_reset_d = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_value    = TMR_W'(SERVE_FRAMES);
                    end
                end
            end
            CLEAR: begin
                if (tmr_done_c) begin
                    level_d      = (level == CNT_W'(MAX_LEVEL)) ? '0 : level + CNT_W'(1);
                    state_d      = SERVE;
                    ball_reset_d = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_value    = TMR_W'(SERVE_FRAMES);
                end
            end
            OVER: begin
                if (launch) begin
                    state_d = IDLE;
                    lives_d = CNT_W'(LIVES);
                    level_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ball_run_d  = (state_d == PLAY);
        paddle_en_d = (state_d == PLAY) || (state_d == SERVE);
        game_over_d = (state_d == OVER);
        score_inc_d = brick_hit && (state_q == PLAY);
    end

endmodule
